sync_fifo_flagged: RTL and testbench

//   Parametrised single-clock FIFO; next generation of the team's basic FIFO.

---
 rtl/sync_fifo_flagged.sv | 149 ++++++++++++++
 tb/tb_sync_fifo_flagged.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and optional first-word-fall-through output.
module sync_fifo_flagged #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned AF_LEVEL   = 14,
    parameter int unsigned AE_LEVEL   = 2,
    parameter int unsigned FWFT       = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  wr_acc_c;
    logic                  rd_acc_c;
    logic [DATA_WIDTH-1:0] head_next_c;

    // Accept decisions; a full FIFO still reads and an empty one still writes.
    always_comb begin
        wr_acc_c = wr_en && !full_q;
        rd_acc_c = rd_en && !empty_q;
    end

    // Pointer, occupancy and flag next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_acc_c) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (rd_acc_c) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end

        case ({wr_acc_c, rd_acc_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        full_d   = (count_d == CNT_W'(FIFO_DEPTH));
        empty_d  = (count_d == CNT_W'(0));
        afull_d  = (count_d >= CNT_W'(AF_LEVEL));
        aempty_d = (count_d <= CNT_W'(AE_LEVEL));

        ovf_d = ovf_q;
        if (wr_en && full_q) begin
            ovf_d = 1'b1;
        end else if (clr_err) begin
            ovf_d = 1'b0;
        end

        unf_d = unf_q;
        if (rd_en && empty_q) begin
            unf_d = 1'b1;
        end else if (clr_err) begin
            unf_d = 1'b0;
        end
    end

    // Read data; in FWFT mode the register preloads the head of the next cycle,
    // bypassing data_in when this cycle's write lands in the head slot.
    always_comb begin
        if (wr_acc_c && (wr_ptr_q == rd_ptr_d)) begin
            head_next_c = data_in;
        end else begin
            head_next_c = mem_q[rd_ptr_d];
        end

        dout_d = dout_q;
        if (FWFT != 0) begin
            dout_d = head_next_c;
        end else if (rd_acc_c) begin
            dout_d = mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is not reset; only accepted writes outside reset touch it.
    always_ff @(posedge CLK) begin
        if (!RST && wr_acc_c) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out     = dout_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Scoreboard bench for sync_fifo_flagged: registered-read instance plus an FWFT instance.
module tb_sync_fifo_flagged;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, wr_en, rd_en, clr_err;
    logic [7:0] din, dout;
    logic       full, empty, af, ae, ovf, unf;
    logic [4:0] cnt;

    logic       f_rst, f_wr_en, f_rd_en, f_clr_err;
    logic [7:0] f_din, f_dout;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [4:0] f_cnt;

    sync_fifo_flagged #(.FWFT(0)) dut (
        .CLK(clk), .RST(rst), .data_in(din), .wr_en(wr_en), .rd_en(rd_en),
        .clr_err(clr_err), .data_out(dout), .full(full), .empty(empty),
        .almost_full(af), .almost_empty(ae), .count(cnt),
        .overflow(ovf), .underflow(unf)
    );

    sync_fifo_flagged #(.FWFT(1)) dut_fwft (
        .CLK(clk), .RST(f_rst), .data_in(f_din), .wr_en(f_wr_en), .rd_en(f_rd_en),
        .clr_err(f_clr_err), .data_out(f_dout), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_cnt),
        .overflow(f_ovf), .underflow(f_unf)
    );

    int         nvec = 0;
    int         nerr = 0;
    logic [7:0] exp_q [$];
    logic [7:0] mon_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Monitor: every accepted read presents data one edge later.
    always @(posedge clk) begin
        if (!rst && rd_en && !empty) begin
            #1;
            nvec++;
            if (exp_q.size() == 0) begin
                nerr++;
                $display("FAIL rd_data: unexpected read, got %0h with empty scoreboard", dout);
            end else begin
                mon_exp = exp_q.pop_front();
                if (dout !== mon_exp) begin
                    nerr++;
                    $display("FAIL rd_data: got %0h expected %0h at %0t", dout, mon_exp, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = '0;
        f_rst = 1'b1; f_wr_en = 1'b0; f_rd_en = 1'b0; f_clr_err = 1'b0; f_din = '0;
        step();
        rst = 1'b0; f_rst = 1'b0;

        // Reset state
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_aempty", 32'(ae), 32'd1);
        chk("rst_count", 32'(cnt), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_afull", 32'(af), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_unf", 32'(unf), 32'd0);

        // Single word round trip
        din = 8'hFA; wr_en = 1'b1; step(); wr_en = 1'b0;
        chk("t2_count", 32'(cnt), 32'd1);
        chk("t2_empty", 32'(empty), 32'd0);
        exp_q.push_back(8'hFA);
        rd_en = 1'b1; step(); rd_en = 1'b0;
        chk("t2_empty_after", 32'(empty), 32'd1);
        chk("t2_count_after", 32'(cnt), 32'd0);

        // Fill to full, overflow, drain across pointer wrap
        for (int i = 0; i < 16; i++) begin
            din = 8'(i); wr_en = 1'b1; step();
            chk("t3_count", 32'(cnt), 32'(i + 1));
            chk("t3_afull", 32'(af), 32'((i + 1) >= 14));
            chk("t3_full", 32'(full), 32'((i + 1) == 16));
            chk("t3_aempty", 32'(ae), 32'((i + 1) <= 2));
        end
        din = 8'hEE; step(); wr_en = 1'b0;
        chk("t3_ovf", 32'(ovf), 32'd1);
        chk("t3_ovf_count", 32'(cnt), 32'd16);
        chk("t3_ovf_full", 32'(full), 32'd1);
        step();
        chk("t3_ovf_sticky", 32'(ovf), 32'd1);
        clr_err = 1'b1; step(); clr_err = 1'b0;
        chk("t3_ovf_clr", 32'(ovf), 32'd0);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(i));
            rd_en = 1'b1; step();
        end
        rd_en = 1'b0;
        chk("t3_drain_empty", 32'(empty), 32'd1);
        chk("t3_drain_count", 32'(cnt), 32'd0);
        chk("t3_drain_unf", 32'(unf), 32'd0);

        // Underflow, data hold, set-over-clear priority
        rd_en = 1'b1; step(); rd_en = 1'b0;
        chk("t4_unf", 32'(unf), 32'd1);
        chk("t4_count", 32'(cnt), 32'd0);
        chk("t4_dout_hold", 32'(dout), 32'h0F);
        rd_en = 1'b1; clr_err = 1'b1; step(); rd_en = 1'b0;
        chk("t4_set_prio", 32'(unf), 32'd1);
        step(); clr_err = 1'b0;
        chk("t4_unf_clr", 32'(unf), 32'd0);

        // Steady-state simultaneous read/write at count 8
        for (int i = 0; i < 8; i++) begin
            din = 8'(8'h10 + i); wr_en = 1'b1; step();
        end
        wr_en = 1'b0;
        chk("t5_fill_count", 32'(cnt), 32'd8);
        for (int i = 0; i < 20; i++) begin
            din = 8'(8'h20 + i); wr_en = 1'b1; rd_en = 1'b1;
            exp_q.push_back((i < 8) ? 8'(8'h10 + i) : 8'(8'h20 + i - 8));
            step();
            chk("t5_count", 32'(cnt), 32'd8);
        end
        wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'(8'h2C + i));
            step();
        end
        rd_en = 1'b0;
        chk("t5_empty", 32'(empty), 32'd1);

        // FWFT head visibility, pop, and mid-operation reset
        f_din = 8'hA5; f_wr_en = 1'b1; step(); f_wr_en = 1'b0;
        chk("t6_head", 32'(f_dout), 32'hA5);
        chk("t6_empty", 32'(f_empty), 32'd0);
        for (int i = 0; i < 4; i++) begin
            f_din = 8'(8'hB0 + i); f_wr_en = 1'b1; step();
        end
        f_wr_en = 1'b0;
        chk("t6_head_hold", 32'(f_dout), 32'hA5);
        chk("t6_count5", 32'(f_cnt), 32'd5);
        f_rd_en = 1'b1; step(); f_rd_en = 1'b0;
        chk("t6_pop_head", 32'(f_dout), 32'hB0);
        chk("t6_pop_count", 32'(f_cnt), 32'd4);
        f_din = 8'hB4; f_wr_en = 1'b1; step(); f_wr_en = 1'b0;
        chk("t6_count_pre_rst", 32'(f_cnt), 32'd5);
        f_rst = 1'b1; step(); f_rst = 1'b0;
        chk("t6_rst_count", 32'(f_cnt), 32'd0);
        chk("t6_rst_empty", 32'(f_empty), 32'd1);
        chk("t6_rst_aempty", 32'(f_ae), 32'd1);

        step();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
